// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch sequencer bus bundle: PC port, byte memory port, IF/ID handshake
interface ifetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_stall;
    logic                  redirect;
    logic                  fetch_req;
    logic                  mem_gnt;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_din;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_ready;

    modport master (
        input  pc, redirect, mem_gnt, mem_din, inst_ready,
        output pc_stall, fetch_req, mem_rd, mem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output pc, redirect, mem_gnt, mem_din, inst_ready,
        input  pc_stall, fetch_req, mem_rd, mem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - byte-serial instruction fetch sequencer with redirect squash
// Optional IFETCH_STAT_EN adds stat_fetched / stat_squashed counters.
module ifetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    ifetch_if.master     bus
`ifdef IFETCH_STAT_EN
    ,
    output logic [31:0]  stat_fetched,
    output logic [31:0]  stat_squashed
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, RD, LAST, HOLD} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [2:0][7:0]       byte_q, byte_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            byte_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign squash = bus.redirect && (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        bus.fetch_req = 1'b0;
        bus.mem_rd    = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                bus.fetch_req = 1'b1;
                if (bus.mem_gnt) begin
                    inst_pc_d = bus.pc;
                    cnt_d     = '0;
                    state_d   = RD;
                end
            end
            RD: begin
                bus.fetch_req = 1'b1;
                bus.mem_rd    = 1'b1;
                // data for the previous strobe arrives one cycle late
                if (cnt_q != 2'd0) byte_d[cnt_q - 2'd1] = bus.mem_din;
                if (cnt_q == 2'd3) state_d = LAST;
                else               cnt_d   = cnt_q + 2'd1;
            end
            LAST: begin
                inst_d  = {bus.mem_din, byte_q[2], byte_q[1], byte_q[0]};
                state_d = HOLD;
            end
            HOLD: if (bus.inst_ready) state_d = REQ;
            default: state_d = IDLE;
        endcase
        // a redirect abandons whatever is in flight and keeps the last handed-off word
        if (squash) begin
            state_d   = REQ;
            cnt_d     = '0;
            byte_d    = '0;
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
        end
    end

    assign bus.pc_stall   = ~(bus.redirect | ((state_q == HOLD) & bus.inst_ready));
    assign bus.inst_valid = (state_q == HOLD) & ~bus.redirect;
    assign bus.mem_addr   = inst_pc_q + ADDR_WIDTH'(cnt_q);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

`ifdef IFETCH_STAT_EN
    logic [31:0] stat_fetched_q, stat_squashed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched_q  <= '0;
            stat_squashed_q <= '0;
        end else begin
            if (bus.inst_valid && bus.inst_ready) stat_fetched_q <= stat_fetched_q + 32'd1;
            if (squash)                           stat_squashed_q <= stat_squashed_q + 32'd1;
        end
    end

    assign stat_fetched  = stat_fetched_q;
    assign stat_squashed = stat_squashed_q;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - directed + randomized bench for ifetch_ctrl against a fetch-phase model
module tb_ifetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();
`ifdef IFETCH_STAT_EN
    logic [31:0] stat_fetched, stat_squashed;
    int          exp_fetched, exp_squashed;
`endif

    ifetch_ctrl #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFETCH_STAT_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_squashed (stat_squashed)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // ph: -1 idle, 0 requesting, 1..4 byte k=ph-1 on the bus, 5 last byte returning, 6 holding
    int          ph;
    logic [31:0] fpc;
    logic        cur_rst, cur_redir, cur_gnt, cur_rdy;
    logic [31:0] cur_pc;
    logic        req_rd;
    logic [31:0] req_addr;

    function automatic logic [7:0] mem_f(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ (a[31:24] + 8'h5a);
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_f(a + 32'd3), mem_f(a + 32'd2), mem_f(a + 32'd1), mem_f(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        logic hold;
        logic on_bus;
        hold   = (ph == 6);
        on_bus = (ph >= 1) && (ph <= 4);
        chk("fetch_req", 32'(bus.fetch_req), 32'((ph >= 0) && (ph <= 4)));
        chk("mem_rd", 32'(bus.mem_rd), 32'(on_bus));
        if (on_bus) chk("mem_addr", bus.mem_addr, fpc + 32'(ph - 1));
        chk("inst_valid", 32'(bus.inst_valid), 32'(hold && !cur_redir));
        chk("pc_stall", 32'(bus.pc_stall), 32'(!(cur_redir || (hold && cur_rdy))));
        if (hold) begin
            chk("inst", bus.inst, word_at(fpc));
            chk("inst_pc", bus.inst_pc, fpc);
        end
`ifdef IFETCH_STAT_EN
        chk("stat_fetched", stat_fetched, 32'(exp_fetched));
        chk("stat_squashed", stat_squashed, 32'(exp_squashed));
`endif
    endtask

    task automatic apply(input logic r, input logic [31:0] p, input logic rd,
                         input logic g, input logic y);
        rst            = r;
        bus.pc         = p;
        bus.redirect   = rd;
        bus.mem_gnt    = g;
        bus.inst_ready = y;
        cur_rst = r; cur_pc = p; cur_redir = rd; cur_gnt = g; cur_rdy = y;
        #1;
        check_outputs();
        req_rd   = bus.mem_rd;
        req_addr = bus.mem_addr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (req_rd) bus.mem_din = mem_f(req_addr);
        if (cur_rst) begin
            ph = -1;
`ifdef IFETCH_STAT_EN
            exp_fetched  = 0;
            exp_squashed = 0;
`endif
        end else begin
`ifdef IFETCH_STAT_EN
            if (cur_redir && ph >= 0) exp_squashed++;
            if (ph == 6 && cur_rdy && !cur_redir) exp_fetched++;
`endif
            if (ph == -1)        ph = 0;
            else if (cur_redir)  ph = 0;
            else if (ph == 0) begin
                if (cur_gnt) begin
                    fpc = cur_pc;
                    ph  = 1;
                end
            end
            else if (ph < 6)     ph++;
            else if (cur_rdy)    ph = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] p, input logic rd,
                       input logic g, input logic y);
        apply(r, p, rd, g, y);
        advance();
    endtask

    initial begin
        rst = 1'b1;
        bus.pc = '0; bus.redirect = 1'b0; bus.mem_gnt = 1'b0;
        bus.inst_ready = 1'b0; bus.mem_din = '0;
        ph = -1; fpc = '0; req_rd = 1'b0; req_addr = '0;
        cur_rst = 1'b1; cur_pc = '0; cur_redir = 1'b0; cur_gnt = 1'b0; cur_rdy = 1'b0;
`ifdef IFETCH_STAT_EN
        exp_fetched = 0; exp_squashed = 0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // reset state
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        advance();

        // first fetch from 0, ready asserted
        repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("plan_inst", bus.inst, 32'h0010_0513);
        chk("plan_stall", 32'(bus.pc_stall), 32'h0);
        advance();

        // backpressure: fetch then six held cycles, then accept
        repeat (12) cyc(1'b0, 32'h4, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h4, 1'b0, 1'b1, 1'b1);

        // grant delayed three cycles, then redirect at byte 2
        repeat (3) cyc(1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 32'h8, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h100, 1'b1, 1'b1, 1'b0);

        // refetch from the new pc; redirect and ready together in HOLD
        repeat (6) cyc(1'b0, 32'h100, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 32'h100, 1'b1, 1'b1, 1'b1);
        chk("redir_hold_valid", 32'(bus.inst_valid), 32'h0);
        advance();

        // address wrap
        repeat (6) cyc(1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);

        // reset at byte 1
        repeat (2) cyc(1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_fetch_req", 32'(bus.fetch_req), 32'h0);
        advance();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic        r, rd, g, y;
            logic [31:0] p;
            r  = ($urandom_range(0, 63) == 0);
            rd = ($urandom_range(0, 7) == 0);
            g  = ($urandom_range(0, 3) != 0);
            y  = ($urandom_range(0, 1) == 1);
            p  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            cyc(r, p, rd, g, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
